cic_ctrl: RTL
=============

Name: cic_ctrl

Overview:
Sequencing controller for the CIC decimator. Generates the input-sample strobe from the system clock, tracks decimation phase, issues output strobes, and owns the decimation ratio R driven into the CIC. On any ratio change it clears the CIC and discards its settling outputs, so R changes cleanly at a decimated-sample boundary.

Parameters:
IN_DIV, 3, system clocks per input sample (18 MHz clk / 3 = 6 MHz input rate)
R_MAX, 16, largest legal decimation ratio (legal range 1..R_MAX)
R_DEFAULT, 8, ratio loaded at reset
CLR_CYCLES, 2, clocks cic_clr is held high
FLUSH_OUT, 2, decimated outputs discarded after a clear

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable
cfg_req  in  1  single-cycle ratio change request
cfg_R  in  5  requested ratio, sampled with cfg_req
cfg_ack  out  1  one-cycle pulse: ratio applied to R_out
cfg_err  out  1  one-cycle pulse: request rejected
R_out  out  5  active ratio to CIC R input
cic_clr  out  1  synchronous clear to CIC integrators/combs
in_stb  out  1  present/accept one input sample this cycle
dec_stb  out  1  CIC produces a decimated sample this cycle
out_valid  out  1  dec_stb qualified (RUN only)
busy  out  1  high in CLEAR/FLUSH or while a ratio change is pending
phase  out  5  current input index within decimation frame, 0..R_out-1

Behaviour:
- Reset (async): state IDLE, R_out=R_DEFAULT, all counters 0, no pending, every other output 0.
- All outputs decoded from registered state; no combinational input-to-output path.
- States: IDLE, CLEAR, FLUSH, RUN.
- IDLE: strobes 0. en=1 -> CLEAR.
- CLEAR: cic_clr=1 for CLR_CYCLES clocks; div_cnt, phase, flush_cnt held 0; then -> FLUSH.
- FLUSH/RUN: div_cnt counts 0..IN_DIV-1, starting at 0 on the first FLUSH cycle. in_stb=1 when div_cnt==IN_DIV-1. phase increments on in_stb and wraps at R_out-1. dec_stb = in_stb && phase==R_out-1.
- FLUSH: out_valid=0. Count dec_stb pulses; after FLUSH_OUT pulses -> RUN on the next cycle.
- RUN: out_valid=dec_stb.
- en=0 in any state -> IDLE next cycle; counters and flush_cnt zeroed; pending request kept.
- cfg_req legality: 1<=cfg_R<=R_MAX. Illegal: cfg_err pulses the next cycle; no state or R_out change.
- Legal in IDLE or CLEAR: R_out=cfg_R and cfg_ack pulse on the next cycle. In CLEAR, the clear count restarts.
- Legal in FLUSH/RUN: latched as pending, busy=1. On the clock edge closing the next dec_stb cycle: R_out=pending, cfg_ack=1, state -> CLEAR, pending cleared. Input and phase sequencing continue unchanged until that edge.
- cfg_req while a pending request exists: rejected with cfg_err; the pending request is unaffected.
- Pending request when en falls: applied in IDLE on the next cycle, with cfg_ack.
- en=0 and cfg_req on the same cycle: en governs the state transition; the request is evaluated as in IDLE.
- R_out=1: dec_stb coincides with every in_stb; phase stays 0.

Test Plan:
1. Reset, then en=1 (defaults) -> R_out=8, cic_clr high exactly 2 clk, then in_stb every 3 clk with the first on the 3rd FLUSH cycle; dec_stb every 24 clk.
2. Continue from 1 -> out_valid stays 0 for the first 2 dec_stb. The first out_valid coincides with the 3rd dec_stb (clk 72 after FLUSH entry) and every 24 clk after that; busy falls on RUN entry.
3. In RUN at phase=3, cfg_req cfg_R=4 -> R_out stays 8 until that frame's dec_stb; the next cycle gives cfg_ack=1, R_out=4, cic_clr for 2 clk. After the flush, dec_stb/out_valid period is 12 clk.
4. cfg_R=0 and cfg_R=17 -> cfg_err one cycle later, R_out unchanged, no clear. A second legal cfg_req while one is pending -> cfg_err, first request still applied.
5. en dropped mid-FLUSH -> IDLE next cycle, in_stb/dec_stb=0, phase=0. rst_n asserted mid-RUN -> outputs reset immediately (before next clk edge), R_out=8.
6. In IDLE, cfg_R=1 and en=1 -> after clear/flush, dec_stb equals in_stb every 3 clk; phase constant 0.

Source files
------------

// File: rtl/cic_ctrl.sv
// Sequencing controller for the CIC decimator: input/output strobes, decimation
// phase, and clean ratio changes (clear + flush) at decimated-sample boundaries.
module cic_ctrl #(
    parameter int IN_DIV     = 3,
    parameter int R_MAX      = 16,
    parameter int R_DEFAULT  = 8,
    parameter int CLR_CYCLES = 2,
    parameter int FLUSH_OUT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cfg_req,
    input  logic [4:0] cfg_R,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic [4:0] R_out,
    output logic       cic_clr,
    output logic       in_stb,
    output logic       dec_stb,
    output logic       out_valid,
    output logic       busy,
    output logic [4:0] phase
);

    localparam int DIV_W   = (IN_DIV > 1) ? $clog2(IN_DIV) : 1;
    localparam int CLR_W   = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int FLUSH_W = (FLUSH_OUT > 1) ? $clog2(FLUSH_OUT) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(IN_DIV - 1);
    localparam logic [CLR_W-1:0]   CLR_LAST   = CLR_W'(CLR_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_OUT - 1);
    localparam logic [4:0]         R_MAX_V    = 5'(R_MAX);

    typedef enum logic [1:0] {IDLE, CLEAR, FLUSH, RUN} state_t;

    state_t             state_q, state_d;
    logic [4:0]         r_q, r_d;
    logic [4:0]         phase_q, phase_d;
    logic [4:0]         pend_r_q, pend_r_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic               pend_q, pend_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    logic running, in_stb_i, dec_stb_i, cfg_legal, cfg_take;

    assign running   = (state_q == FLUSH) || (state_q == RUN);
    assign in_stb_i  = running && (div_q == DIV_LAST);
    assign dec_stb_i = in_stb_i && (phase_q == r_q - 5'd1);
    assign cfg_legal = (cfg_R != 5'd0) && (cfg_R <= R_MAX_V);
    assign cfg_take  = cfg_req && cfg_legal && !pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= IDLE;
            r_q      <= 5'(R_DEFAULT);
            phase_q  <= '0;
            pend_r_q <= '0;
            div_q    <= '0;
            clr_q    <= '0;
            flush_q  <= '0;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            phase_q  <= phase_d;
            pend_r_q <= pend_r_d;
            div_q    <= div_d;
            clr_q    <= clr_d;
            flush_q  <= flush_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the branches below can infer a latch.
        state_d  = state_q;
        r_d      = r_q;
        phase_d  = phase_q;
        pend_r_d = pend_r_q;
        div_d    = div_q;
        clr_d    = clr_q;
        flush_d  = flush_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        // A request left pending when en fell is applied once we sit in IDLE.
        if (state_q == IDLE && pend_q) begin
            r_d    = pend_r_q;
            ack_d  = 1'b1;
            pend_d = 1'b0;
        end

        if (cfg_req && !cfg_take) begin
            err_d = 1'b1;
        end else if (cfg_take) begin
            if (!en || state_q == IDLE || state_q == CLEAR) begin
                r_d   = cfg_R;
                ack_d = 1'b1;
            end else begin
                pend_d   = 1'b1;
                pend_r_d = cfg_R;
            end
        end

        if (!en) begin
            state_d = IDLE;
            div_d   = '0;
            phase_d = '0;
            clr_d   = '0;
            flush_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CLEAR;
                    clr_d   = '0;
                end
                CLEAR: begin
                    if (cfg_take) begin
                        clr_d = '0;
                    end else if (clr_q == CLR_LAST) begin
                        state_d = FLUSH;
                        clr_d   = '0;
                    end else begin
                        clr_d = clr_q + CLR_W'(1);
                    end
                end
                FLUSH, RUN: begin
                    div_d = in_stb_i ? '0 : div_q + DIV_W'(1);
                    if (in_stb_i)
                        phase_d = dec_stb_i ? 5'd0 : phase_q + 5'd1;
                    // Ratio swap lands on the edge closing a decimated sample.
                    if (dec_stb_i && pend_q) begin
                        r_d     = pend_r_q;
                        ack_d   = 1'b1;
                        pend_d  = 1'b0;
                        state_d = CLEAR;
                        div_d   = '0;
                        phase_d = '0;
                        flush_d = '0;
                        clr_d   = '0;
                    end else if (dec_stb_i && state_q == FLUSH) begin
                        if (flush_q == FLUSH_LAST) begin
                            state_d = RUN;
                            flush_d = '0;
                        end else begin
                            flush_d = flush_q + FLUSH_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cic_clr   = (state_q == CLEAR);
        in_stb    = in_stb_i;
        dec_stb   = dec_stb_i;
        out_valid = (state_q == RUN) && dec_stb_i;
        busy      = (state_q == CLEAR) || (state_q == FLUSH) || pend_q;
        phase     = phase_q;
        R_out     = r_q;
        cfg_ack   = ack_q;
        cfg_err   = err_q;
    end

endmodule
